// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and the
// baud divisor rounding used by both the transmitter and the future receiver.
package uart_tx_fifo_param_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// Synchronous FIFO with the head word presented combinationally on rdata, so a
// consumer can pop and use the data in the same cycle. Pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter on the system clock with an internal per-bit divider and a
// small input FIFO; frames are sent back-to-back while the FIFO holds data.
module uart_tx_fifo_param
  import uart_tx_fifo_param_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(DIV - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 load;
  logic                 baud_last;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW-1:0]       fifo_count;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        load   = !fifo_empty;
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        // Registered pulse lands on the final cycle of the last stop bit.
        done_d = (bit_q == STOP_LAST) && (baud_q == BAUD_PRE);
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            load    = !fifo_empty;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d = ST_START;
      baud_d  = '0;
      tx_d    = 1'b0;
      shift_d = fifo_rdata;
      par_d   = (PARITY == PARITY_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: seven configurations checked every cycle
// against a queue-of-line-samples model plus directed literal expectations.
module tb_uart_tx_fifo_param;

  localparam int NI = 7;
  localparam int CLKS   [NI] = '{1000000, 1000000, 1000000, 1000000, 1000000, 12000000, 12000000};
  localparam int BAUDS  [NI] = '{100000, 100000, 100000, 100000, 100000, 115200, 9600};
  localparam int DIVS   [NI] = '{10, 10, 10, 10, 10, 104, 1250};
  localparam int DBS    [NI] = '{8, 8, 8, 7, 8, 8, 8};
  localparam int PARS   [NI] = '{0, 2, 1, 1, 0, 0, 0};
  localparam int SBS    [NI] = '{1, 1, 1, 2, 1, 1, 1};
  localparam int DEPTHS [NI] = '{4, 4, 4, 4, 2, 4, 4};

  typedef struct packed {
    logic tx;
    logic done;
    logic inframe;
    logic first;
  } samp_t;

  localparam samp_t IDLE_S = '{tx: 1'b1, done: 1'b0, inframe: 1'b0, first: 1'b0};

  logic          clk = 1'b0;
  logic [NI-1:0] rst_r;
  logic [NI-1:0] vld_r;
  logic [8:0]    dat_r [NI];
  logic [NI-1:0] rdy_w;
  logic [NI-1:0] tx_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo_param #(
      .CLK_FREQ   (CLKS[g]),
      .BAUD       (BAUDS[g]),
      .DATA_BITS  (DBS[g]),
      .PARITY     (PARS[g]),
      .STOP_BITS  (SBS[g]),
      .FIFO_DEPTH (DEPTHS[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst_r[g]),
      .tx_data  (dat_r[g][DBS[g]-1:0]),
      .tx_valid (vld_r[g]),
      .tx_ready (rdy_w[g]),
      .tx       (tx_w[g]),
      .busy     (busy_w[g]),
      .tx_done  (done_w[g])
    );
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: the expected line as a queue of per-cycle samples per instance.
  samp_t mq  [NI][$];
  samp_t cur [NI];
  int    mcnt [NI];
  bit    acc_last [NI];

  bit rec_tx   [0:1399];
  bit rec_done [0:1399];
  bit rec_busy [0:1399];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic append_frame(input int i, input logic [8:0] d);
    bit    lv[$];
    int    ones;
    samp_t s;
    ones = 0;
    lv.push_back(1'b0);
    for (int b = 0; b < DBS[i]; b++) begin
      lv.push_back(d[b]);
      ones += int'(d[b]);
    end
    if (PARS[i] == 1) lv.push_back((ones % 2) == 0);
    else if (PARS[i] == 2) lv.push_back((ones % 2) == 1);
    for (int k = 0; k < SBS[i]; k++) lv.push_back(1'b1);
    for (int k = 0; k < lv.size(); k++) begin
      for (int c = 0; c < DIVS[i]; c++) begin
        s.tx      = lv[k];
        s.first   = (k == 0) && (c == 0);
        s.done    = (k == lv.size() - 1) && (c == DIVS[i] - 1);
        s.inframe = 1'b1;
        mq[i].push_back(s);
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit acc;
      if (rst_r[i]) begin
        mq[i].delete();
        cur[i]      = IDLE_S;
        mcnt[i]     = 0;
        acc_last[i] = 1'b0;
      end else begin
        acc = vld_r[i] && (mcnt[i] != DEPTHS[i]);
        cur[i] = (mq[i].size() > 0) ? mq[i].pop_front() : IDLE_S;
        if (cur[i].first) mcnt[i]--;
        if (acc) begin
          append_frame(i, dat_r[i]);
          mcnt[i]++;
        end
        acc_last[i] = acc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("tx", i, 32'(tx_w[i]), 32'(cur[i].tx));
        chk("tx_done", i, 32'(done_w[i]), 32'(cur[i].done));
        chk("busy", i, 32'(busy_w[i]), 32'(cur[i].inframe || (mcnt[i] != 0)));
        chk("tx_ready", i, 32'(rdy_w[i]), 32'(mcnt[i] != DEPTHS[i]));
      end
    end
  end

  task automatic push(input int i, input logic [8:0] d);
    @(negedge clk);
    vld_r[i] = 1'b1;
    dat_r[i] = d;
    @(negedge clk);
    vld_r[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      rec_tx[k]   = tx_w[i];
      rec_done[k] = done_w[i];
      rec_busy[k] = busy_w[i];
    end
  endtask

  function automatic int count_done(input int n);
    int s = 0;
    for (int k = 1; k <= n; k++) s += int'(rec_done[k]);
    return s;
  endfunction

  function automatic int count_high(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(rec_tx[k]);
    return s;
  endfunction

  function automatic int low_run();
    int k = 1;
    while (k < 1400 && rec_tx[k] == 1'b0) k++;
    return k - 1;
  endfunction

  initial begin
    int idx;
    int cyc;
    int ndone;
    int done_t [5];
    bit rdy_low_seen;

    for (int i = 0; i < NI; i++) begin
      cur[i]      = IDLE_S;
      mcnt[i]     = 0;
      acc_last[i] = 1'b0;
      dat_r[i]    = '0;
    end
    rst_r = '1;
    vld_r = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst_r  = '0;
    for (int i = 0; i < NI; i++) begin
      chk("reset_tx", i, 32'(tx_w[i]), 32'd1);
      chk("reset_ready", i, 32'(rdy_w[i]), 32'd1);
      chk("reset_busy", i, 32'(busy_w[i]), 32'd0);
      chk("reset_done", i, 32'(done_w[i]), 32'd0);
    end

    // 8N1, 0x55
    push(0, 9'h055);
    chk("model_len_8n1", 0, mq[0].size(), 32'd100);
    capture(0, 105);
    chk("t1_start_first", 0, 32'(rec_tx[1]), 32'd0);
    chk("t1_start_last", 0, 32'(rec_tx[10]), 32'd0);
    chk("t1_bit0", 0, 32'(rec_tx[11]), 32'd1);
    chk("t1_bit0_end", 0, 32'(rec_tx[20]), 32'd1);
    chk("t1_bit1", 0, 32'(rec_tx[21]), 32'd0);
    chk("t1_bit7", 0, 32'(rec_tx[90]), 32'd0);
    chk("t1_stop", 0, 32'(rec_tx[91]), 32'd1);
    chk("t1_done_99", 0, 32'(rec_done[99]), 32'd0);
    chk("t1_done_100", 0, 32'(rec_done[100]), 32'd1);
    chk("t1_done_count", 0, count_done(105), 32'd1);
    chk("t1_busy_100", 0, 32'(rec_busy[100]), 32'd1);
    chk("t1_busy_101", 0, 32'(rec_busy[101]), 32'd0);

    // even then odd parity, 0x07
    push(1, 9'h007);
    capture(1, 115);
    chk("t2e_par_first", 1, 32'(rec_tx[91]), 32'd1);
    chk("t2e_par_last", 1, 32'(rec_tx[100]), 32'd1);
    chk("t2e_done_100", 1, 32'(rec_done[100]), 32'd0);
    chk("t2e_done_110", 1, 32'(rec_done[110]), 32'd1);
    push(2, 9'h007);
    capture(2, 115);
    chk("t2o_par_first", 2, 32'(rec_tx[91]), 32'd0);
    chk("t2o_par_last", 2, 32'(rec_tx[100]), 32'd0);
    chk("t2o_stop", 2, 32'(rec_tx[101]), 32'd1);
    chk("t2o_done_110", 2, 32'(rec_done[110]), 32'd1);

    // 7O2, 0x41
    push(3, 9'h041);
    chk("model_len_7o2", 3, mq[3].size(), 32'd110);
    capture(3, 115);
    chk("t3_bit0", 3, 32'(rec_tx[11]), 32'd1);
    chk("t3_bit1", 3, 32'(rec_tx[21]), 32'd0);
    chk("t3_bit5", 3, 32'(rec_tx[61]), 32'd0);
    chk("t3_bit6", 3, 32'(rec_tx[71]), 32'd1);
    chk("t3_parity", 3, 32'(rec_tx[81]), 32'd1);
    chk("t3_stop_high", 3, count_high(91, 110), 32'd20);
    chk("t3_done_100", 3, 32'(rec_done[100]), 32'd0);
    chk("t3_done_110", 3, 32'(rec_done[110]), 32'd1);
    chk("t3_busy_111", 3, 32'(rec_busy[111]), 32'd0);

    // depth-2 FIFO, valid held through 0x30..0x34
    @(negedge clk);
    vld_r[4] = 1'b1;
    dat_r[4] = 9'h030;
    idx = 0;
    cyc = 0;
    ndone = 0;
    rdy_low_seen = 1'b0;
    while (ndone < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (acc_last[4]) begin
        idx++;
        if (idx < 5) dat_r[4] = 9'(9'h030 + idx);
        else vld_r[4] = 1'b0;
      end
      if (!rdy_w[4]) rdy_low_seen = 1'b1;
      if (done_w[4]) begin
        done_t[ndone] = cyc;
        ndone++;
      end
    end
    vld_r[4] = 1'b0;
    chk("t4_done_count", 4, ndone, 32'd5);
    chk("t4_accepted", 4, idx, 32'd5);
    chk("t4_ready_low", 4, 32'(rdy_low_seen), 32'd1);
    for (int k = 1; k < 5; k++) begin
      if (k < ndone) chk("t4_done_spacing", 4, done_t[k] - done_t[k-1], 32'd100);
    end
    repeat (5) @(negedge clk);

    // reset mid-frame, then a clean frame
    push(0, 9'h055);
    repeat (44) @(negedge clk);
    rst_r[0] = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    chk("t5_tx_after_rst", 0, 32'(tx_w[0]), 32'd1);
    chk("t5_ready_after_rst", 0, 32'(rdy_w[0]), 32'd1);
    chk("t5_busy_after_rst", 0, 32'(busy_w[0]), 32'd0);
    capture(0, 110);
    chk("t5_no_done", 0, count_done(110), 32'd0);
    push(0, 9'h0A3);
    capture(0, 105);
    chk("t5_start", 0, 32'(rec_tx[1]), 32'd0);
    chk("t5_bit0", 0, 32'(rec_tx[11]), 32'd1);
    chk("t5_bit1", 0, 32'(rec_tx[21]), 32'd1);
    chk("t5_bit2", 0, 32'(rec_tx[31]), 32'd0);
    chk("t5_bit7", 0, 32'(rec_tx[81]), 32'd1);
    chk("t5_done_100", 0, 32'(rec_done[100]), 32'd1);
    chk("t5_done_count", 0, count_done(105), 32'd1);

    // real clock: 115200 and 9600 baud start bits
    push(5, 9'h055);
    capture(5, 1300);
    chk("t6_start_115200", 5, low_run(), 32'd104);
    chk("t6_bit0_115200", 5, 32'(rec_tx[105]), 32'd1);
    push(6, 9'h055);
    capture(6, 1300);
    chk("t6_start_9600", 6, low_run(), 32'd1250);
    chk("t6_bit0_9600", 6, 32'(rec_tx[1251]), 32'd1);
    repeat (12500 - 1300 + 20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter that runs directly on the 12 MHz system clock. It uses an internal baud divider and does not use a derived baud clock. Configurable data width, parity and stop bits; a small input FIFO with valid/ready handshake allows bytes to be queued back-to-back. Replaces the fixed 8N1 baud-clocked transmitter in top-level demo designs. The top level drives tx_data/tx_valid from user logic, and tx goes to the FTDI TX pin.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = (CLK_FREQ + BAUD/2) / BAUD clock cycles per bit (1250 at defaults); DIV >= 2 required
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, queued frames, power of two >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
tx_data  input  DATA_BITS  payload, sampled when tx_valid && tx_ready
tx_valid  input  1  producer offers tx_data
tx_ready  output  1  FIFO not full; registered
tx  output  1  serial line, idle high; registered
busy  output  1  frame in progress or FIFO non-empty
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit

Behaviour:
- Reset (synchronous, rst high at a clock edge): tx=1, tx_ready=1, busy=0, tx_done=0, FIFO emptied, FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame immediately: tx is high after that edge and no tx_done is produced.
- Handshake: a push happens when tx_valid && tx_ready at an edge. tx_ready = (count != FIFO_DEPTH), computed from the registered count. A simultaneous pop does not make a full FIFO accept. Push and pop in the same cycle leave count unchanged.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop into shift register and enter START. tx=0 from the edge following the accepting edge, so latency is 1 cycle after acceptance with an empty FIFO.
  - START: tx=0 for DIV cycles.
  - DATA: DATA_BITS bits, LSB first, DIV cycles each.
  - PARITY: present only if PARITY != 0; DIV cycles. Odd parity makes the total ones in data+parity odd; even parity makes it even.
  - STOP: tx=1 for STOP_BITS*DIV cycles.
- Baud counter counts 0..DIV-1 and restarts at 0 on every state entry, so each bit is exactly DIV cycles. No drift; there is no free-running tick.
- End of STOP: tx_done=1 for exactly one cycle. If the FIFO is non-empty, pop and enter START directly with zero idle cycles between frames. Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles.
- busy = (state != IDLE) || (count != 0).
- Bit counter width is clog2(DATA_BITS+1). The FIFO wraps its read and write pointers modulo FIFO_DEPTH.

Decomposition:
- Shared header uart_defs.vh holds:
  - parity encodings (PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2);
  - FSM state localparams;
  - the DIV rounding formula as a macro, reused by the future uart_rx.
- One sub-module, uart_tx_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: clk, rst, push, wdata, pop, rdata, full, empty, count.
  - Read data is valid combinationally at the head, so the FSM pops and loads in the same cycle.

Test Plan:
1. Bench override CLK_FREQ=1000000, BAUD=100000 (DIV=10), 8N1. Push 0x55 -> tx low cycles 1-10; then 1,0,1,0,1,0,1,0 for 10 cycles each; high 10 cycles; tx_done pulse at cycle 100; busy drops the cycle after.
2. PARITY=2, push 0x07 -> parity bit 1 (cycles 91-100), frame 110 cycles. PARITY=1, push 0x07 -> parity bit 0.
3. DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x41 -> bits 1,0,0,0,0,0,1; parity 1; tx high for 20 cycles; tx_done at cycle 110.
4. FIFO_DEPTH=2, hold tx_valid with 0x30..0x34 -> tx_ready low whenever count=2; all 5 bytes sent in order; tx_done pulses exactly 100 cycles apart; tx never high more than 10 cycles between frames.
5. Assert rst at cycle 45 of a frame -> tx=1, tx_ready=1, busy=0 after that edge; no tx_done. Next pushed 0xA3 transmits correctly from its start bit.
6. Defaults with BAUD=115200 -> DIV=104; start bit lasts exactly 104 clk cycles. Default BAUD=9600 -> 1250 cycles.
